// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates a CPU and a program loader onto one SRAM/IO port.
// Each access holds the memory signals for WAIT_CYCLES cycles, then pulses the
// winner's ack for one cycle.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests. Without it, the CPU always wins a tie.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata stable and
// holds it until it sees its one-cycle *_ack. Operands are latched at grant,
// so dropping req mid-access does not cancel the access. A req still high in
// the cycle after ack is a new request.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic        ldr_ack,
  output logic [15:0] ldr_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        grant_ldr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lat_we, lat_we_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic        grant_q, grant_nxt;
  logic [15:0] cpu_rd_q, cpu_rd_nxt;
  logic [15:0] ldr_rd_q, ldr_rd_nxt;
  logic        pick_ldr;

  // Winner selection for a request seen in IDLE.
  always_comb begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // On a tie the loader wins only if the CPU had the previous grant.
    pick_ldr = ldr_req & (~cpu_req | ~grant_q);
`else
    // CPU has fixed priority; the loader wins only when alone.
    pick_ldr = ldr_req & ~cpu_req;
`endif
  end

  // State register and latched access operands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      grant_q  <= 1'b1;
      cpu_rd_q <= 16'h0000;
      ldr_rd_q <= 16'h0000;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_we   <= lat_we_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      grant_q  <= grant_nxt;
      cpu_rd_q <= cpu_rd_nxt;
      ldr_rd_q <= ldr_rd_nxt;
    end
  end

  // Next-state logic: grant in IDLE, count down in ACCESS, ack in DONE.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    lat_we_nxt = lat_we;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    grant_nxt  = grant_q;
    cpu_rd_nxt = cpu_rd_q;
    ldr_rd_nxt = ldr_rd_q;
    case (state)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          state_nxt  = ACCESS;
          cnt_nxt    = WAIT_LOAD;
          grant_nxt  = pick_ldr;
          lat_we_nxt = pick_ldr ? ldr_we    : cpu_we;
          addr_nxt   = pick_ldr ? ldr_addr  : cpu_addr;
          wdata_nxt  = pick_ldr ? ldr_wdata : cpu_wdata;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          // Read data is sampled on the last hold cycle only.
          if (!lat_we) begin
            if (grant_q) ldr_rd_nxt = mem_rdata;
            else         cpu_rd_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory strobes exist only in ACCESS; address/data hold between accesses.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state == ACCESS) &  lat_we;
  assign mem_oe    = (state == ACCESS) & ~lat_we;
  assign cpu_ack   = (state == DONE) & ~grant_q;
  assign ldr_ack   = (state == DONE) &  grant_q;
  assign cpu_rdata = cpu_rd_q;
  assign ldr_rdata = ldr_rd_q;
  assign busy      = (state != IDLE);
  assign grant_ldr = grant_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter (WAIT_CYCLES=2).
// Define SRAM_ARB_ROUND_ROBIN_EN for both RTL and bench to check the round-robin build.
module tb_sram_arbiter;

  localparam int unsigned W = 2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Clock and DUT signals
  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_ack, ldr_ack, mem_oe, mem_we, busy, grant_ldr;
  logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  // Emulated SRAM seen by the DUT, and the reference model's memory
  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [logic [15:0]];

  // Reference model state: who was granted last, expected read registers,
  // last operands presented to memory
  bit          last_ldr;
  logic [15:0] exp_cpu_rd, exp_ldr_rd, last_addr, last_wd;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  assign mem_rdata = mem_arr[mem_addr];

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_ldr(grant_ldr), .dbg_state(dbg_state)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    mem_arr[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic model_reset();
    last_ldr   = 1'b1;
    exp_cpu_rd = 16'h0000;
    exp_ldr_rd = 16'h0000;
    last_addr  = 16'h0000;
    last_wd    = 16'h0000;
  endtask

  // One arbitration round. Called just after a rising edge of an IDLE cycle;
  // returns just after the rising edge of the next IDLE cycle (WAIT_CYCLES+2 later).
  task automatic round(input bit c_req, input bit c_we, input logic [15:0] c_addr,
                       input logic [15:0] c_wd, input bit l_req, input bit l_we,
                       input logic [15:0] l_addr, input logic [15:0] l_wd,
                       input bit drop_mid, output bit win_ldr);
    bit          w_we;
    logic [15:0] w_addr, w_wd, rd;
    if (c_req && l_req) win_ldr = RR ? !last_ldr : 1'b0;
    else                win_ldr = l_req;
    w_we   = win_ldr ? l_we   : c_we;
    w_addr = win_ldr ? l_addr : c_addr;
    w_wd   = win_ldr ? l_wd   : c_wd;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    ldr_req = l_req; ldr_we = l_we; ldr_addr = l_addr; ldr_wdata = l_wd;
    @(negedge Clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_oe", mem_oe, 1'b0);
    chk1("idle_we", mem_we, 1'b0);
    chk1("idle_cpu_ack", cpu_ack, 1'b0);
    chk1("idle_ldr_ack", ldr_ack, 1'b0);
    chk16("idle_addr_hold", mem_addr, last_addr);
    chk16("idle_wdata_hold", mem_wdata, last_wd);
    for (int i = 1; i <= int'(W); i++) begin
      @(posedge Clk); #1;
      if (drop_mid) begin
        if (win_ldr) ldr_req = 1'b0;
        else         cpu_req = 1'b0;
      end
      @(negedge Clk);
      chk1("acc_busy", busy, 1'b1);
      chk1("acc_oe", mem_oe, !w_we);
      chk1("acc_we", mem_we, w_we);
      chk16("acc_addr", mem_addr, w_addr);
      chk16("acc_wdata", mem_wdata, w_wd);
      chk1("acc_cpu_ack", cpu_ack, 1'b0);
      chk1("acc_ldr_ack", ldr_ack, 1'b0);
      chk1("acc_grant", grant_ldr, win_ldr);
      if (mem_we === 1'b1) mem_arr[mem_addr] = mem_wdata;
    end
    if (w_we) ref_mem[w_addr] = w_wd;
    else begin
      rd = ref_read(w_addr);
      if (win_ldr) exp_ldr_rd = rd;
      else         exp_cpu_rd = rd;
    end
    last_ldr  = win_ldr;
    last_addr = w_addr;
    last_wd   = w_wd;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk1("done_busy", busy, 1'b1);
    chk1("done_oe", mem_oe, 1'b0);
    chk1("done_we", mem_we, 1'b0);
    chk1("done_cpu_ack", cpu_ack, !win_ldr);
    chk1("done_ldr_ack", ldr_ack, win_ldr);
    chk16("done_cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk16("done_ldr_rdata", ldr_rdata, exp_ldr_rd);
    chk16("done_addr_hold", mem_addr, w_addr);
    @(posedge Clk); #1;
  endtask

  initial begin
    bit          wl, cr, lr, cw, lw, dm;
    logic [3:0]  order;
    logic [15:0] ca, la, cd, ld;
    int          pick;

    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'(i) ^ 16'h5A5A;
    model_reset();

    // Reset
    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0; ldr_wdata = 16'h0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_ldr_ack", ldr_ack, 1'b0);
    chk16("rst_cpu_rdata", cpu_rdata, 16'h0000);
    chk16("rst_ldr_rdata", ldr_rdata, 16'h0000);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk1("rst_mem_oe", mem_oe, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_grant_ldr", grant_ldr, 1'b1);
    @(posedge Clk); #1;

    // Both requesters held for four write transactions
    for (int k = 0; k < 4; k++) begin
      round(1'b1, 1'b1, 16'h0100 + 16'(k), 16'hC000 + 16'(k),
            1'b1, 1'b1, 16'h0200 + 16'(k), 16'hD000 + 16'(k), 1'b0, wl);
      order[k] = wl;
    end
    chk16("tie_order", {12'h000, order}, RR ? 16'h000A : 16'h0000);

    // CPU read 0x3000
    preload(16'h3000, 16'hBEEF);
    round(1'b1, 1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, wl);
    chk16("cpu_read_data", cpu_rdata, 16'hBEEF);
    chk16("cpu_read_ldr_rdata", ldr_rdata, 16'h0000);

    // Loader write 0x0010 <- 0x1234
    round(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, wl);
    chk16("ldr_write_addr", mem_addr, 16'h0010);
    chk16("ldr_write_data", mem_wdata, 16'h1234);

    // CPU read of the top address
    preload(16'hFFFF, 16'h03FF);
    round(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, wl);
    chk16("top_read_data", cpu_rdata, 16'h03FF);
    chk16("top_read_addr", mem_addr, 16'hFFFF);

    // Randomized traffic, including mid-access request drops
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(1, 3);
      cr = pick[0]; lr = pick[1];
      cw = 1'($urandom_range(0, 1));
      lw = 1'($urandom_range(0, 1));
      ca = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
      la = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
      cd = 16'($urandom);
      ld = 16'($urandom);
      dm = ($urandom_range(0, 3) == 0);
      round(cr, cw, ca, cd, lr, lw, la, ld, dm, wl);
    end

    // CPU write aborted by reset in its first access cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 16'hA5A5;
    ldr_req = 1'b0;
    @(negedge Clk);
    chk1("abort_idle_busy", busy, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk1("abort_c1_we", mem_we, 1'b1);
    @(posedge Clk); #1;
    Reset = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    for (int c = 0; c < W + 2; c++) begin
      @(negedge Clk);
      chk1("abort_we", mem_we, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_cpu_ack", cpu_ack, 1'b0);
      @(posedge Clk); #1;
    end
    chk16("abort_cpu_rdata", cpu_rdata, 16'h0000);
    chk1("abort_grant", grant_ldr, 1'b1);
    chk16("abort_addr", mem_addr, 16'h0000);

    // Recovery after reset
    round(1'b1, 1'b0, 16'h0042, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, wl);
    round(1'b1, 1'b0, 16'h0042, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, wl);
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (2) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, SRAM access hold time in cycles; legal range 1..15.
REQ-002 Port: Clk  input  1  clock; all state changes on rising edge.
REQ-003 Port: Reset  input  1  reset; synchronous, active-high.
REQ-004 Port: cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 Port: cpu_we  input  1  CPU request is a write (1) or read (0).
REQ-006 Port: cpu_addr  input  16  CPU word address.
REQ-007 Port: cpu_wdata  input  16  CPU write data.
REQ-008 Port: cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 Port: cpu_rdata  output  16  registered CPU read data, valid from cpu_ack onward.
REQ-010 Port: ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  same directions/widths as CPU ports  program-loader requester.
REQ-011 Port: mem_addr  output  16  address to memory/IO path.
REQ-012 Port: mem_oe  output  1  read enable to memory/IO path.
REQ-013 Port: mem_we  output  1  write enable to memory/IO path.
REQ-014 Port: mem_wdata  output  16  write data to memory/IO path.
REQ-015 Port: mem_rdata  input  16  read data from memory/IO path.
REQ-016 Port: busy  output  1  high whenever state is not IDLE.
REQ-017 Port: grant_ldr  output  1  current or last grant belongs to loader.

Function
REQ-018 States: IDLE, ACCESS, DONE; 4-bit wait counter.
REQ-019 IDLE: no req -> stay; any req -> select winner, latch its we/addr/wdata, load counter WAIT_CYCLES-1, go ACCESS.
REQ-020 ACCESS: mem_addr/mem_wdata = latched values; mem_we = latched we; mem_oe = ~latched we; decrement counter; at counter 0 capture mem_rdata (reads only) into winner's rdata register, go DONE.
REQ-021 DONE: mem_oe = mem_we = 0; winner's ack = 1 for exactly this cycle; go IDLE.
REQ-022 Latency: req sampled in IDLE at cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> ack in cycle WAIT_CYCLES+1.
REQ-023 mem_oe and mem_we never both 1; both 0 outside ACCESS.
REQ-024 Outside ACCESS, mem_addr/mem_wdata hold last latched values.
REQ-025 Non-winner's ack stays 0 and its rdata register unchanged.
REQ-026 req still high in cycle after ack = new request, arbitrated in IDLE.
REQ-027 req dropped mid-access: access completes, ack still pulsed.
REQ-028 Addresses pass unmodified, including 0xFFFF (IO decode belongs downstream).
REQ-029 Minimum period between accesses: WAIT_CYCLES+2 cycles.

Reset
REQ-030 Reset -> state IDLE, counter 0, cpu_ack = ldr_ack = 0, cpu_rdata = ldr_rdata = 0, mem_addr = mem_wdata = 0, mem_oe = mem_we = 0, busy = 0, grant_ldr = 1.
REQ-031 Reset mid-ACCESS/DONE aborts access; no ack issued; mem_we = 0 from the following cycle.

Configuration
REQ-032 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, winner is the requester not granted last (grant_ldr tracks last grant); lone request always wins.
REQ-033 Macro undefined: fixed priority, CPU wins every simultaneous request; loader may starve.

Verification (WAIT_CYCLES=2)
REQ-034 CPU read 0x3000, mem_rdata=0xBEEF -> mem_oe=1 cycles 1-2, mem_we=0, cpu_ack cycle 3, cpu_rdata=0xBEEF, ldr_rdata=0.
REQ-035 Loader write 0x0010/0x1234 -> mem_we=1 cycles 1-2, mem_addr=0x0010, mem_wdata=0x1234, mem_oe=0, ldr_ack cycle 3.
REQ-036 Both req held for 4 transactions -> without macro CPU,CPU,CPU,CPU; with macro CPU,LDR,CPU,LDR.
REQ-037 CPU write; Reset in cycle 1 -> mem_we=0 and busy=0 from cycle 2, no cpu_ack.
REQ-038 CPU read 0xFFFF, mem_rdata=0x03FF -> mem_addr=0xFFFF, cpu_rdata=0x03FF at ack.
